// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider / enable generator.
// Effective-value helpers work on 32-bit words; callers size-cast the result.
package clk_div_pkg;

  typedef enum logic {
    StSettle = 1'b0,
    StRun    = 1'b1
  } lock_state_e;

  typedef logic [31:0] word_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A half-period of zero behaves as one: divide-by-2.
  function automatic word_t eff_half(input word_t half);
    return (half == '0) ? word_t'(1) : half;
  endfunction

  // Out-of-range phases fall back to zero.
  function automatic word_t eff_phase(input word_t half, input word_t phase);
    return (phase < eff_half(half)) ? phase : '0;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, square output and rising-edge enable.
module clk_div_ch #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] half_eff,
  input  logic [CNT_W-1:0] phase_eff,
  output logic             c,
  output logic             ce
);

  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic             ce_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      c_q   <= 1'b0;
      ce_q  <= 1'b0;
    end else if (load) begin
      cnt_q <= phase_eff;
      c_q   <= 1'b0;
      ce_q  <= 1'b0;
    end else if (run) begin
      if (cnt_q == half_eff - CNT_W'(1)) begin
        cnt_q <= '0;
        c_q   <= ~c_q;
        ce_q  <= ~c_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        ce_q  <= 1'b0;
      end
    end else begin
      // Counter holds while settling; output is forced low so channels realign.
      c_q  <= 1'b0;
      ce_q <= 1'b0;
    end
  end

  assign c  = c_q;
  assign ce = ce_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider producing square outputs, clock enables and a lock flag.
// Any accepted config write forces a full resettle so all channels restart aligned.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned                NUM_CH      = 3,
  parameter int unsigned                CNT_W       = 16,
  parameter int unsigned                LOCK_CYCLES = 64,
  parameter logic [NUM_CH*CNT_W-1:0]    HALF_INIT   = {16'd60, 16'd8, 16'd2},
  parameter logic [NUM_CH*CNT_W-1:0]    PHASE_INIT  = '0,
  localparam int unsigned               CH_W        = clog2_min1(NUM_CH)
) (
  input  logic              inclk0,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] c_out,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked,
  output logic              relock_evt
);

  localparam int unsigned LCW = clog2_min1(LOCK_CYCLES);

  logic [CNT_W-1:0] half_q  [NUM_CH];
  logic [CNT_W-1:0] phase_q [NUM_CH];
  lock_state_e      state_q;
  logic [LCW-1:0]   lock_cnt_q;
  logic             locked_q;
  logic             relock_q;

  logic wr_acc;
  logic lock_done;
  logic ch_run;
  logic ch_load;

  assign wr_acc    = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign lock_done = (lock_cnt_q == LCW'(LOCK_CYCLES - 1));
  assign ch_run    = (state_q == StRun) && !wr_acc;
  assign ch_load   = (state_q == StSettle) && lock_done && !wr_acc;

  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i]  <= HALF_INIT[i*CNT_W +: CNT_W];
        phase_q[i] <= PHASE_INIT[i*CNT_W +: CNT_W];
      end
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (32'(cfg_ch) == i) begin
          half_q[i]  <= cfg_half;
          phase_q[i] <= cfg_phase;
        end
      end
    end
  end

  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      state_q    <= StSettle;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      relock_q   <= 1'b0;
    end else if (wr_acc) begin
      state_q    <= StSettle;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      relock_q   <= (state_q == StRun);
    end else begin
      relock_q <= 1'b0;
      if (state_q == StSettle) begin
        if (lock_done) begin
          state_q    <= StRun;
          lock_cnt_q <= '0;
          locked_q   <= 1'b1;
        end else begin
          lock_cnt_q <= lock_cnt_q + LCW'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] half_eff;
    logic [CNT_W-1:0] phase_eff;

    assign half_eff  = CNT_W'(eff_half(word_t'(half_q[i])));
    assign phase_eff = CNT_W'(eff_phase(word_t'(half_q[i]), word_t'(phase_q[i])));

    clk_div_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (inclk0),
      .rst_n    (rst_n),
      .run      (ch_run),
      .load     (ch_load),
      .half_eff (half_eff),
      .phase_eff(phase_eff),
      .c        (c_out[i]),
      .ce       (ce_out[i])
    );
  end

  assign locked     = locked_q;
  assign relock_evt = relock_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: timeline-based reference model plus pinned literals.
module tb_clk_div_gen;

  localparam int LC = 64;

  logic        inclk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_half = '0;
  logic [15:0] cfg_phase = '0;
  logic [2:0]  c_out;
  logic [2:0]  ce_out;
  logic        locked;
  logic        relock_evt;

  int checks = 0;
  int failures = 0;

  // Model: outputs follow from the edge index of the most recent settle start.
  int n = 0;
  int t_start = 0;
  int half_m[3];
  int phase_m[3];
  bit relock_m = 0;
  bit valid = 0;

  clk_div_gen u_dut (
    .inclk0    (inclk0),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_phase (cfg_phase),
    .c_out     (c_out),
    .ce_out    (ce_out),
    .locked    (locked),
    .relock_evt(relock_evt)
  );

  always #5 inclk0 = ~inclk0;

  function automatic int heff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int peff(input int h, input int p);
    return (p < heff(h)) ? p : 0;
  endfunction

  function automatic bit m_locked();
    return valid && ((n - t_start) >= LC);
  endfunction

  // Virtual phase m: output is high during odd multiples of half-period.
  function automatic bit m_c(input int i);
    int k, h, m;
    if (!m_locked()) return 1'b0;
    k = n - t_start - LC;
    h = heff(half_m[i]);
    m = k + peff(half_m[i], phase_m[i]);
    return ((m / h) % 2) == 1;
  endfunction

  function automatic bit m_ce(input int i);
    int k, h, m;
    if (!m_locked()) return 1'b0;
    k = n - t_start - LC;
    h = heff(half_m[i]);
    m = k + peff(half_m[i], phase_m[i]);
    return (m % (2 * h)) == h;
  endfunction

  task automatic model_edge();
    bit was_locked;
    was_locked = m_locked();
    n++;
    if (!rst_n) begin
      half_m   = '{2, 8, 60};
      phase_m  = '{0, 0, 0};
      t_start  = n;
      relock_m = 1'b0;
      valid    = 1'b1;
    end else if (cfg_we && cfg_ch < 2'd3) begin
      half_m[cfg_ch]  = int'(cfg_half);
      phase_m[cfg_ch] = int'(cfg_phase);
      t_start  = n;
      relock_m = was_locked;
    end else begin
      relock_m = 1'b0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  always @(negedge inclk0) begin
    if (valid) begin
      check("model_locked", int'(locked), int'(m_locked()));
      check("model_relock", int'(relock_evt), int'(relock_m));
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_c%0d", i), int'(c_out[i]), int'(m_c(i)));
        check($sformatf("model_ce%0d", i), int'(ce_out[i]), int'(m_ce(i)));
      end
    end
  end

  task automatic step();
    @(posedge inclk0);
    model_edge();
    @(negedge inclk0);
  endtask

  task automatic cfg_write(input int ch, input int h, input int p);
    cfg_we    = 1'b1;
    cfg_ch    = ch[1:0];
    cfg_half  = h[15:0];
    cfg_phase = p[15:0];
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int ce_cnt[3];
    int op;

    // Reset release with defaults.
    step();
    step();
    rst_n = 1'b1;
    check("reset_c_out", int'(c_out), 0);
    check("reset_locked", int'(locked), 0);
    repeat (LC - 1) step();
    check("lock_edge63", int'(locked), 0);
    step();
    check("lock_edge64", int'(locked), 1);
    check("run_entry_c", int'(c_out), 0);
    step();
    step();
    check("ch0_first_rise", int'(c_out[0]), 1);
    check("ch0_first_ce", int'(ce_out[0]), 1);
    check("ch1_not_yet", int'(c_out[1]), 0);
    ce_cnt = '{0, 0, 0};
    repeat (1200) begin
      step();
      for (int i = 0; i < 3; i++) ce_cnt[i] += int'(ce_out[i]);
    end
    check("ce_count_ch0", ce_cnt[0], 300);
    check("ce_count_ch1", ce_cnt[1], 75);
    check("ce_count_ch2", ce_cnt[2], 10);

    // Reconfigure ch1 in RUN.
    cfg_write(1, 5, 3);
    check("relock_pulse", int'(relock_evt), 1);
    check("relock_locked", int'(locked), 0);
    check("relock_c_held", int'(c_out), 0);
    step();
    check("relock_single", int'(relock_evt), 0);
    repeat (LC - 2) step();
    check("relock_edge63", int'(locked), 0);
    step();
    check("relock_edge64", int'(locked), 1);
    step();
    check("ch1_before_rise", int'(c_out[1]), 0);
    step();
    check("ch1_rise_2in", int'(c_out[1]), 1);
    check("ch0_aligned", int'(c_out[0]), 1);
    repeat (200) step();

    // half=0 acts as divide-by-2.
    cfg_write(0, 0, 7);
    repeat (LC) step();
    check("h0_locked", int'(locked), 1);
    step();
    check("h0_c_k1", int'(c_out[0]), 1);
    check("h0_ce_k1", int'(ce_out[0]), 1);
    step();
    check("h0_c_k2", int'(c_out[0]), 0);
    check("h0_ce_k2", int'(ce_out[0]), 0);
    step();
    check("h0_c_k3", int'(c_out[0]), 1);
    repeat (50) step();

    // Out-of-range channel is ignored.
    cfg_write(3, 9, 9);
    check("bad_ch_relock", int'(relock_evt), 0);
    check("bad_ch_locked", int'(locked), 1);
    repeat (50) step();

    // Write during SETTLE restarts the count without a relock pulse.
    cfg_write(2, 7, 2);
    repeat (40) step();
    cfg_write(2, 9, 20);
    check("settle_wr_relock", int'(relock_evt), 0);
    repeat (LC - 1) step();
    check("settle_wr_edge63", int'(locked), 0);
    step();
    check("settle_wr_edge64", int'(locked), 1);
    repeat (300) step();

    // Reset wins over a simultaneous write.
    rst_n     = 1'b0;
    cfg_we    = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 16'd3;
    cfg_phase = 16'd0;
    step();
    rst_n  = 1'b1;
    cfg_we = 1'b0;
    check("rst_wr_c", int'(c_out), 0);
    check("rst_wr_locked", int'(locked), 0);
    repeat (LC) step();
    step();
    step();
    check("rst_wr_init_ch0", int'(c_out[0]), 1);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        rst_n  = 1'b0;
        cfg_we = $urandom_range(0, 1) == 1;
        step();
        rst_n  = 1'b1;
        cfg_we = 1'b0;
      end else if (op < 7) begin
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 25)));
      end
      repeat ($urandom_range(1, 150)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
